// File: rtl/hwpe_stream_protocol_monitor.sv
// ---------------------------------------------------------------------------
// hwpe_stream_protocol_monitor
//
// Passive run-time checker for NB_CH HWPE stream handshakes. It flags three
// sticky per-channel errors:
//   - VCR:   data changed while a transfer was stalled (valid & ~ready).
//   - VDR:   valid dropped while a transfer was stalled.
//   - STALL: valid & ~ready held for STALL_TIMEOUT consecutive cycles
//            (STALL_TIMEOUT = 0 disables this check).
// It also captures the first error seen and counts handshakes per channel.
// Every output comes from a flop, so there is no combinational path from the
// tapped stream to the outputs.
//
// Optional feature macro: HWPE_STREAM_MON_STRB_CHECK_EN
//   defined   : a strobe change during a stall also raises VCR.
//   undefined : mon_strb_i is ignored and strobes are not registered.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   clear_i                 synchronous soft clear (same effect as rst_i)
//   enable_i[NB_CH]         per-channel check enable
//   mon_valid_i/ready_i     tapped handshake, one bit per channel
//   mon_data_i/strb_i       tapped payload, channel c at [c*W +: W]
//   err_vcr_o/vdr_o/stall_o sticky per-channel errors
//   err_any_o               OR of all sticky errors
//   first_err_valid_o/ch_o/code_o  first error capture (01 VCR, 10 VDR, 11 STALL)
//   hs_cnt_o                saturating per-channel handshake counters
// ---------------------------------------------------------------------------
module hwpe_stream_protocol_monitor #(
  parameter int unsigned NB_CH         = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned STALL_TIMEOUT = 1024,
  localparam int unsigned CH_W         = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic [NB_CH-1:0]              enable_i,
  input  logic [NB_CH-1:0]              mon_valid_i,
  input  logic [NB_CH-1:0]              mon_ready_i,
  input  logic [NB_CH*DATA_WIDTH-1:0]   mon_data_i,
  input  logic [NB_CH*DATA_WIDTH/8-1:0] mon_strb_i,
  output logic [NB_CH-1:0]              err_vcr_o,
  output logic [NB_CH-1:0]              err_vdr_o,
  output logic [NB_CH-1:0]              err_stall_o,
  output logic                          err_any_o,
  output logic                          first_err_valid_o,
  output logic [CH_W-1:0]               first_err_ch_o,
  output logic [1:0]                    first_err_code_o,
  output logic [NB_CH*CNT_WIDTH-1:0]    hs_cnt_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned SC_W   = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [SC_W-1:0] STALL_MAX  = SC_W'(STALL_TIMEOUT);
  localparam logic [SC_W-1:0] STALL_LAST = SC_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
  localparam logic [1:0] CODE_VCR   = 2'b01;
  localparam logic [1:0] CODE_VDR   = 2'b10;
  localparam logic [1:0] CODE_STALL = 2'b11;

  logic [NB_CH-1:0]                 prev_valid_q, prev_valid_d;
  logic [NB_CH-1:0]                 prev_ready_q, prev_ready_d;
  logic [NB_CH-1:0]                 hist_q, hist_d;
  logic [NB_CH*DATA_WIDTH-1:0]      prev_data_q, prev_data_d;
  logic [NB_CH-1:0][SC_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [NB_CH-1:0][CNT_WIDTH-1:0]  hs_cnt_q, hs_cnt_d;
  logic [NB_CH-1:0]                 err_vcr_q, err_vcr_d;
  logic [NB_CH-1:0]                 err_vdr_q, err_vdr_d;
  logic [NB_CH-1:0]                 err_stall_q, err_stall_d;
  logic                             first_err_valid_q, first_err_valid_d;
  logic [CH_W-1:0]                  first_err_ch_q, first_err_ch_d;
  logic [1:0]                       first_err_code_q, first_err_code_d;

  logic [NB_CH-1:0]                 armed, data_chg, stall_now;
  logic [NB_CH-1:0]                 vcr_ev, vdr_ev, stall_ev;

`ifdef HWPE_STREAM_MON_STRB_CHECK_EN
  logic [NB_CH*STRB_W-1:0]          prev_strb_q, prev_strb_d;
`else
  logic                             unused_strb;
  assign unused_strb = ^mon_strb_i;
`endif

  always_comb begin
    prev_valid_d      = mon_valid_i;
    prev_ready_d      = mon_ready_i;
    prev_data_d       = mon_data_i;
    // History is only meaningful if the previous cycle was enabled too.
    hist_d            = enable_i;
    stall_cnt_d       = stall_cnt_q;
    hs_cnt_d          = hs_cnt_q;
    armed             = '0;
    data_chg          = '0;
    stall_now         = '0;
    vcr_ev            = '0;
    vdr_ev            = '0;
    stall_ev          = '0;
    first_err_valid_d = first_err_valid_q;
    first_err_ch_d    = first_err_ch_q;
    first_err_code_d  = first_err_code_q;
`ifdef HWPE_STREAM_MON_STRB_CHECK_EN
    prev_strb_d       = mon_strb_i;
`endif

    for (int c = 0; c < NB_CH; c++) begin
      // A transfer was offered but not accepted last cycle: payload must hold.
      armed[c]    = enable_i[c] & hist_q[c] & prev_valid_q[c] & ~prev_ready_q[c];
      data_chg[c] = mon_data_i[c*DATA_WIDTH +: DATA_WIDTH] != prev_data_q[c*DATA_WIDTH +: DATA_WIDTH];
`ifdef HWPE_STREAM_MON_STRB_CHECK_EN
      data_chg[c] = data_chg[c] | (mon_strb_i[c*STRB_W +: STRB_W] != prev_strb_q[c*STRB_W +: STRB_W]);
`endif
      vcr_ev[c]    = armed[c] & data_chg[c];
      vdr_ev[c]    = armed[c] & ~mon_valid_i[c];

      stall_now[c] = enable_i[c] & mon_valid_i[c] & ~mon_ready_i[c];
      if ((STALL_TIMEOUT != 0) && stall_now[c]) begin
        // Counter saturates at the timeout; the error fires only on the
        // cycle that brings it there.
        if (stall_cnt_q[c] != STALL_MAX) stall_cnt_d[c] = stall_cnt_q[c] + 1'b1;
        stall_ev[c] = (stall_cnt_q[c] == STALL_LAST);
      end else begin
        stall_cnt_d[c] = '0;
      end

      if (enable_i[c] && mon_valid_i[c] && mon_ready_i[c] && (hs_cnt_q[c] != '1))
        hs_cnt_d[c] = hs_cnt_q[c] + 1'b1;
    end

    err_vcr_d   = err_vcr_q | vcr_ev;
    err_vdr_d   = err_vdr_q | vdr_ev;
    err_stall_d = err_stall_q | stall_ev;

    // Scan from the top down so the lowest-indexed channel is written last.
    if (!first_err_valid_q) begin
      for (int c = NB_CH - 1; c >= 0; c--) begin
        if (vcr_ev[c] || vdr_ev[c] || stall_ev[c]) begin
          first_err_valid_d = 1'b1;
          first_err_ch_d    = CH_W'(c);
          first_err_code_d  = vcr_ev[c] ? CODE_VCR : (vdr_ev[c] ? CODE_VDR : CODE_STALL);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      prev_valid_q      <= '0;
      prev_ready_q      <= '0;
      hist_q            <= '0;
      stall_cnt_q       <= '0;
      hs_cnt_q          <= '0;
      err_vcr_q         <= '0;
      err_vdr_q         <= '0;
      err_stall_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_ch_q    <= '0;
      first_err_code_q  <= '0;
    end else begin
      prev_valid_q      <= prev_valid_d;
      prev_ready_q      <= prev_ready_d;
      hist_q            <= hist_d;
      stall_cnt_q       <= stall_cnt_d;
      hs_cnt_q          <= hs_cnt_d;
      err_vcr_q         <= err_vcr_d;
      err_vdr_q         <= err_vdr_d;
      err_stall_q       <= err_stall_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_ch_q    <= first_err_ch_d;
      first_err_code_q  <= first_err_code_d;
    end
  end

  // Payload history is qualified by hist_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    prev_data_q <= prev_data_d;
`ifdef HWPE_STREAM_MON_STRB_CHECK_EN
    prev_strb_q <= prev_strb_d;
`endif
  end

  assign err_vcr_o         = err_vcr_q;
  assign err_vdr_o         = err_vdr_q;
  assign err_stall_o       = err_stall_q;
  assign err_any_o         = |{err_vcr_q, err_vdr_q, err_stall_q};
  assign first_err_valid_o = first_err_valid_q;
  assign first_err_ch_o    = first_err_ch_q;
  assign first_err_code_o  = first_err_code_q;
  assign hs_cnt_o          = hs_cnt_q;

endmodule

// File: tb/tb_hwpe_stream_protocol_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for hwpe_stream_protocol_monitor (NB_CH=2, DATA_WIDTH=32,
// CNT_WIDTH=16, STALL_TIMEOUT=4). Directed scenarios followed by randomized
// traffic, all checked against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_hwpe_stream_protocol_monitor;

  localparam int NB_CH = 2;
  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int TO    = 4;
  localparam int HSMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [1:0]  en, vld, rdy;
  logic [63:0] data;
  logic [7:0]  strb;
  logic [1:0]  err_vcr, err_vdr, err_stall;
  logic        err_any, fe_valid;
  logic [0:0]  fe_ch;
  logic [1:0]  fe_code;
  logic [31:0] hs_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hwpe_stream_protocol_monitor #(
    .NB_CH(NB_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .STALL_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(en),
    .mon_valid_i(vld), .mon_ready_i(rdy), .mon_data_i(data), .mon_strb_i(strb),
    .err_vcr_o(err_vcr), .err_vdr_o(err_vdr), .err_stall_o(err_stall),
    .err_any_o(err_any), .first_err_valid_o(fe_valid), .first_err_ch_o(fe_ch),
    .first_err_code_o(fe_code), .hs_cnt_o(hs_cnt)
  );

  // Reference model state: what the previous cycle looked like, how long each
  // channel has been stalled, and the accumulated results.
  bit        m_pv[NB_CH], m_pr[NB_CH], m_hist[NB_CH];
  bit [31:0] m_pd[NB_CH];
  int        m_run[NB_CH], m_hs[NB_CH];
  bit [1:0]  m_vcr, m_vdr, m_stall;
  bit        m_fv;
  int        m_fch;
  bit [1:0]  m_fcode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [1:0] ev_vcr, ev_vdr, ev_st;
    ev_vcr = '0; ev_vdr = '0; ev_st = '0;
    if (rst || clear) begin
      for (int c = 0; c < NB_CH; c++) begin
        m_pv[c] = 0; m_pr[c] = 0; m_hist[c] = 0; m_pd[c] = 0; m_run[c] = 0; m_hs[c] = 0;
      end
      m_vcr = '0; m_vdr = '0; m_stall = '0; m_fv = 0; m_fch = 0; m_fcode = '0;
    end else begin
      for (int c = 0; c < NB_CH; c++) begin
        bit stalled_before;
        stalled_before = en[c] && m_hist[c] && m_pv[c] && !m_pr[c];
        ev_vcr[c] = stalled_before && (data[c*DW +: DW] != m_pd[c]);
        ev_vdr[c] = stalled_before && !vld[c];
        if (en[c] && vld[c] && !rdy[c]) begin
          if (TO > 0 && m_run[c] < TO) begin
            m_run[c]++;
            ev_st[c] = (m_run[c] == TO);
          end
        end else begin
          m_run[c] = 0;
        end
        if (en[c] && vld[c] && rdy[c] && m_hs[c] < HSMAX) m_hs[c]++;
      end
      m_vcr   |= ev_vcr;
      m_vdr   |= ev_vdr;
      m_stall |= ev_st;
      for (int c = 0; c < NB_CH; c++) begin
        if (!m_fv && (ev_vcr[c] || ev_vdr[c] || ev_st[c])) begin
          m_fv    = 1;
          m_fch   = c;
          m_fcode = ev_vcr[c] ? 2'd1 : (ev_vdr[c] ? 2'd2 : 2'd3);
        end
      end
      for (int c = 0; c < NB_CH; c++) begin
        m_pv[c] = vld[c]; m_pr[c] = rdy[c]; m_pd[c] = data[c*DW +: DW]; m_hist[c] = en[c];
      end
    end
  endtask

  task automatic compare_all();
    chk("err_vcr", err_vcr, m_vcr);
    chk("err_vdr", err_vdr, m_vdr);
    chk("err_stall", err_stall, m_stall);
    chk("err_any", err_any, |{m_vcr, m_vdr, m_stall});
    chk("fe_valid", fe_valid, m_fv);
    if (m_fv) begin
      chk("fe_ch", fe_ch, m_fch);
      chk("fe_code", fe_code, m_fcode);
    end
    chk("hs_cnt0", hs_cnt[15:0], m_hs[0]);
    chk("hs_cnt1", hs_cnt[31:16], m_hs[1]);
  endtask

  // Inputs are stable here; advance the model, clock the DUT, sample at +1.
  task automatic step(input bit do_chk);
    model_step();
    @(posedge clk);
    #1;
    if (do_chk) compare_all();
  endtask

  task automatic idle();
    rst = 0; clear = 0; en = 2'b11; vld = '0; rdy = '0; data = '0; strb = '0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1;
    step(1);
    clear = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1;
    step(0);
    step(1);
    chk("rst_err_any", err_any, 0);
    chk("rst_fe_valid", fe_valid, 0);
    chk("rst_hs", hs_cnt, 0);
    rst = 0;

    // Legal traffic on ch0
    vld = 2'b01; rdy = 2'b01;
    for (int i = 0; i < 10; i++) begin
      data[31:0] = 32'(i);
      step(1);
    end
    chk("t1_hs0", hs_cnt[15:0], 10);
    chk("t1_err_any", err_any, 0);
    chk("t1_fe_valid", fe_valid, 0);

    // VCR on ch1
    do_clear();
    vld = 2'b10; rdy = 2'b00; data[63:32] = 32'hA5;
    step(1);
    data[63:32] = 32'h5A;
    step(1);
    chk("t2_vcr", err_vcr, 2'b10);
    chk("t2_fe_ch", fe_ch, 1);
    chk("t2_fe_code", fe_code, 2'b01);

    // VDR on ch0
    do_clear();
    vld = 2'b01; rdy = 2'b00; data[31:0] = 32'h7;
    step(1);
    vld = 2'b00;
    step(1);
    chk("t3_vdr0", err_vdr[0], 1);
    chk("t3_err_any", err_any, 1);

    // Stall timeout on ch0
    do_clear();
    vld = 2'b01; rdy = 2'b00; data[31:0] = 32'h33;
    for (int i = 1; i <= TO; i++) begin
      step(1);
      chk("t4_stall0", err_stall[0], (i == TO) ? 1 : 0);
    end
    chk("t4_no_vcr", err_vcr, 0);
    chk("t4_no_vdr", err_vdr, 0);

    // Simultaneous VDR on ch0 and VCR on ch1
    do_clear();
    vld = 2'b11; rdy = 2'b00; data = {32'h1, 32'h9};
    step(1);
    vld = 2'b10; data = {32'h2, 32'h9};
    step(1);
    chk("t5_fe_ch", fe_ch, 0);
    chk("t5_fe_code", fe_code, 2'b10);
    chk("t5_vdr", err_vdr, 2'b01);
    chk("t5_vcr", err_vcr, 2'b10);

    // Violation pending when clear pulses, then counter saturation
    do_clear();
    vld = 2'b01; rdy = 2'b00; data[31:0] = 32'h1;
    step(1);
    data[31:0] = 32'h2; clear = 1;
    step(1);
    chk("t6_clr_err_any", err_any, 0);
    chk("t6_clr_fe_valid", fe_valid, 0);
    chk("t6_clr_hs", hs_cnt, 0);
    clear = 0; data[31:0] = 32'h3;
    step(1);
    chk("t6_post_err_any", err_any, 0);

    do_clear();
    vld = 2'b01; rdy = 2'b01;
    for (int i = 0; i < HSMAX + 5; i++) step(0);
    chk("t6_hs_sat", hs_cnt[15:0], 16'hFFFF);
    compare_all();

    // Randomized traffic
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 500) == 0;
      clear = ($urandom % 50) == 0;
      for (int c = 0; c < NB_CH; c++) begin
        en[c]  = ($urandom % 8) != 0;
        vld[c] = ($urandom % 4) != 0;
        rdy[c] = ($urandom % 3) == 0;
        if (($urandom % 4) == 0) data[c*DW +: DW] = 32'($urandom % 4);
      end
      strb = 8'($urandom);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
